glycemic_sample_scheduler: RTL and testbench

Sequences a single shared `GlycemicIndexCalculator` among `NUM_CH` blood-sensor channels. Grants channels round-robin over a valid/ready handshake, latches the accepted sample, and drives it onto the calculator's `bloodSensor` input. Waits a programmable settle time, captures `glycemicIndex`, and presents the result with its channel number on a valid/ready output port. Sits between the per-patient sensor front-ends and the display/logging logic.

---
 rtl/glycemic_sample_scheduler.sv | 151 +++++++++++++++
 tb/tb_glycemic_sample_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glycemic_sample_scheduler.sv
// Round-robin arbiter that time-shares one GlycemicIndexCalculator among NUM_CH sensor channels.
// Optional per-channel sticky alarm is enabled by defining GLYCEMIC_ALARM_EN.
`timescale 1ns/1ps
module glycemic_sample_scheduler #(
  parameter int NUM_CH        = 4,
  parameter int CH_W          = $clog2(NUM_CH),
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [NUM_CH-1:0]     reqValid,
  input  logic [8*NUM_CH-1:0]   reqData,
  output logic [NUM_CH-1:0]     reqReady,
  output logic [7:0]            calcSensor,
  input  logic [3:0]            calcIndex,
  output logic                  resValid,
  input  logic                  resReady,
  output logic [3:0]            resIndex,
  output logic [CH_W-1:0]       resChannel,
  output logic                  busy,
  input  logic [3:0]            alarmThreshold,
  input  logic [NUM_CH-1:0]     alarmClear,
  output logic [NUM_CH-1:0]     alarm
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t            state_r;
  logic [CH_W-1:0]   ptr;
  logic [7:0]        sampleReg;
  logic [CNT_W-1:0]  settleCnt_r;
  logic [NUM_CH-1:0] grant_s;
  logic [CH_W-1:0]   grantCh_s;
  logic [CH_W-1:0]   nextPtr_s;
  logic              captureEdge_s;

  // Rotating-priority search: scan from the farthest slot down so the slot nearest ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_s   = '0;
    grantCh_s = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (reqValid[idx]) begin
        grant_s   = NUM_CH'(1) << idx;
        grantCh_s = CH_W'(idx);
      end else begin
        grant_s   = grant_s;
        grantCh_s = grantCh_s;
      end
    end
  end

  // Pointer advances past the channel just served, wrapping at NUM_CH.
  always_comb begin
    if (resChannel == CH_W'(NUM_CH - 1)) begin
      nextPtr_s = '0;
    end else begin
      nextPtr_s = resChannel + CH_W'(1);
    end
  end

  assign captureEdge_s = (state_r == SETTLE) && (settleCnt_r == '0);
  assign reqReady      = (state_r == IDLE) ? grant_s : '0;
  assign calcSensor    = sampleReg;

  // Main sequencer: accept, settle, capture, hand off.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_r     <= IDLE;
      ptr         <= '0;
      sampleReg   <= 8'h00;
      settleCnt_r <= '0;
      resIndex    <= 4'h0;
      resChannel  <= '0;
      resValid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|grant_s) begin
            sampleReg   <= reqData[{grantCh_s, 3'b000} +: 8];
            resChannel  <= grantCh_s;
            settleCnt_r <= CNT_W'(SETTLE_CYCLES - 1);
            busy        <= 1'b1;
            state_r     <= SETTLE;
          end
        end
        SETTLE: begin
          if (settleCnt_r == '0) begin
            resIndex <= calcIndex;
            resValid <= 1'b1;
            state_r  <= RESULT;
          end else begin
            settleCnt_r <= settleCnt_r - CNT_W'(1);
          end
        end
        RESULT: begin
          if (resReady) begin
            resValid <= 1'b0;
            busy     <= 1'b0;
            ptr      <= nextPtr_s;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          resValid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef GLYCEMIC_ALARM_EN
  logic [NUM_CH-1:0] alarm_r;
  logic [NUM_CH-1:0] alarmSet_s;

  // Threshold compare uses the live calculator output at the capture edge.
  always_comb begin
    if (captureEdge_s && (calcIndex >= alarmThreshold)) begin
      alarmSet_s = NUM_CH'(1) << resChannel;
    end else begin
      alarmSet_s = '0;
    end
  end

  // Sticky alarms; a set on the same edge overrides a clear.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      alarm_r <= '0;
    end else begin
      alarm_r <= (alarm_r & ~alarmClear) | alarmSet_s;
    end
  end

  assign alarm = alarm_r;
`else
  logic unusedAlarmInputs_s;
  assign unusedAlarmInputs_s = ^{alarmThreshold, alarmClear};
  assign alarm = '0;
`endif

endmodule

// File: tb/tb_glycemic_sample_scheduler.sv
// Scoreboard bench for glycemic_sample_scheduler with a stub calculator (index = sensor[7:4]).
`timescale 1ns/1ps
module tb_glycemic_sample_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic [3:0]  reqValid, reqReady, alarmClear, alarm;
  logic [31:0] reqData;
  logic [7:0]  calcSensor;
  logic [3:0]  calcIndex, resIndex, alarmThreshold;
  logic        resValid, resReady, busy;
  logic [1:0]  resChannel;

  logic [3:0]  reqValid3, reqReady3, alarmClear3, alarm3;
  logic [31:0] reqData3;
  logic [7:0]  calcSensor3;
  logic [3:0]  calcIndex3, resIndex3;
  logic        resValid3, resReady3, busy3;
  logic [1:0]  resChannel3;

  assign calcIndex  = calcSensor[7:4];
  assign calcIndex3 = calcSensor3[7:4];

  glycemic_sample_scheduler #(.NUM_CH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
    .calcSensor(calcSensor), .calcIndex(calcIndex), .resValid(resValid), .resReady(resReady),
    .resIndex(resIndex), .resChannel(resChannel), .busy(busy),
    .alarmThreshold(alarmThreshold), .alarmClear(alarmClear), .alarm(alarm)
  );

  glycemic_sample_scheduler #(.NUM_CH(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rstN(rstN), .reqValid(reqValid3), .reqData(reqData3), .reqReady(reqReady3),
    .calcSensor(calcSensor3), .calcIndex(calcIndex3), .resValid(resValid3), .resReady(resReady3),
    .resIndex(resIndex3), .resChannel(resChannel3), .busy(busy3),
    .alarmThreshold(alarmThreshold), .alarmClear(alarmClear3), .alarm(alarm3)
  );

`ifdef GLYCEMIC_ALARM_EN
  localparam logic [3:0] ALARM_CH2 = 4'b0100;
`else
  localparam logic [3:0] ALARM_CH2 = 4'b0000;
`endif

  typedef struct {
    logic [1:0] ch;
    logic [3:0] idx;
  } exp_t;

  exp_t exp1[$];
  exp_t exp3[$];
  exp_t e1, e3;
  int   resTimes[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cycle   = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [1:0] ch, input logic [3:0] idx);
    exp_t e;
    e.ch = ch;
    e.idx = idx;
    exp1.push_back(e);
  endtask

  // Monitor for the SETTLE_CYCLES=1 instance: every result handshake pops the scoreboard.
  always @(negedge clk) begin
    if (rstN && resValid && resReady) begin
      resTimes.push_back(cycle);
      if (exp1.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL dut1 unexpected result: got ch %0d idx 0x%0h, required none", resChannel, resIndex);
      end else begin
        e1 = exp1.pop_front();
        check("dut1 resChannel", 32'(resChannel), 32'(e1.ch));
        check("dut1 resIndex", 32'(resIndex), 32'(e1.idx));
      end
    end
  end

  // Monitor for the SETTLE_CYCLES=3 instance.
  always @(negedge clk) begin
    if (rstN && resValid3 && resReady3) begin
      if (exp3.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL dut3 unexpected result: got ch %0d idx 0x%0h, required none", resChannel3, resIndex3);
      end else begin
        e3 = exp3.pop_front();
        check("dut3 resChannel", 32'(resChannel3), 32'(e3.ch));
        check("dut3 resIndex", 32'(resIndex3), 32'(e3.idx));
      end
    end
  end

  initial begin
    exp_t e;
    int   bound;
    rstN = 1'b0;
    reqValid = 4'b0000; reqData = {8'h40, 8'h30, 8'h20, 8'hEE}; resReady = 1'b0;
    alarmThreshold = 4'hF; alarmClear = 4'b0000;
    reqValid3 = 4'b0000; reqData3 = {8'h00, 8'h55, 8'h9D, 8'h00}; resReady3 = 1'b0;
    alarmClear3 = 4'b0000;

    // Reset state
    tick(); tick();
    check("reset resValid", 32'(resValid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset reqReady", 32'(reqReady), 32'd0);
    check("reset calcSensor", 32'(calcSensor), 32'd0);
    check("reset resIndex", 32'(resIndex), 32'd0);
    check("reset resChannel", 32'(resChannel), 32'd0);
    check("reset alarm", 32'(alarm), 32'd0);
    check("reset dut3 busy", 32'(busy3), 32'd0);
    rstN = 1'b1;

    // Single request on channel 0
    tick();
    reqValid = 4'b0001; resReady = 1'b1;
    push1(2'd0, 4'hE);
    #1 check("single reqReady grant", 32'(reqReady), 32'h1);
    tick();
    check("single reqReady after accept", 32'(reqReady), 32'h0);
    check("single busy", 32'(busy), 32'd1);
    check("single calcSensor", 32'(calcSensor), 32'hEE);
    check("single resValid early", 32'(resValid), 32'd0);
    reqValid = 4'b0000;
    tick();
    check("single resValid", 32'(resValid), 32'd1);
    tick();
    check("single resValid drop", 32'(resValid), 32'd0);
    check("single busy drop", 32'(busy), 32'd0);

    // All four channels held valid after reset: strict rotation, 3-cycle period
    reqData = {8'h40, 8'h30, 8'h20, 8'h10};
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    resTimes.delete();
    reqValid = 4'b1111;
    push1(2'd0, 4'h1); push1(2'd1, 4'h2); push1(2'd2, 4'h3); push1(2'd3, 4'h4); push1(2'd0, 4'h1);
    bound = 0;
    while (resTimes.size() < 5 && bound < 40) begin
      tick();
      bound++;
    end
    reqValid = 4'b0000;
    check("rotation result count", 32'(resTimes.size()), 32'd5);
    for (int i = 1; i < resTimes.size(); i++) begin
      check("rotation spacing", 32'(resTimes[i] - resTimes[i-1]), 32'd3);
    end
    tick(); tick();

    // Backpressure: ch2 result held while others request
    reqValid = 4'b0100; resReady = 1'b0;
    push1(2'd2, 4'h3);
    tick();
    reqValid = 4'b1111;
    bound = 0;
    while (!resValid && bound < 10) begin
      tick();
      bound++;
    end
    check("backpressure resValid seen", 32'(resValid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("backpressure resIndex", 32'(resIndex), 32'h3);
      check("backpressure resChannel", 32'(resChannel), 32'd2);
      check("backpressure reqReady", 32'(reqReady), 32'h0);
      check("backpressure busy", 32'(busy), 32'd1);
      tick();
    end
    resReady = 1'b1;
    tick();
    check("backpressure resValid fall", 32'(resValid), 32'd0);
    check("backpressure next grant ch3", 32'(reqReady), 32'h8);
    reqValid = 4'b0000;
    tick();

    // SETTLE_CYCLES=3: sample 0x9D on ch1
    reqValid3 = 4'b0010;
    e.ch = 2'd1; e.idx = 4'h9; exp3.push_back(e);
    #1 check("settle3 reqReady grant", 32'(reqReady3), 32'h2);
    tick();
    reqValid3 = 4'b0000;
    check("settle3 busy", 32'(busy3), 32'd1);
    check("settle3 resValid +1", 32'(resValid3), 32'd0);
    tick();
    check("settle3 resValid +2", 32'(resValid3), 32'd0);
    tick();
    check("settle3 resValid +3 pre", 32'(resValid3), 32'd0);
    tick();
    check("settle3 resValid +3", 32'(resValid3), 32'd1);
    check("settle3 resIndex", 32'(resIndex3), 32'h9);
    resReady3 = 1'b1;
    tick();
    check("settle3 resValid drop", 32'(resValid3), 32'd0);

    // Reset during SETTLE aborts the sample and restarts rotation at ch0
    reqValid3 = 4'b0100;
    tick();
    reqValid3 = 4'b0000;
    check("abort busy in settle", 32'(busy3), 32'd1);
    rstN = 1'b0;
    tick();
    check("abort resValid", 32'(resValid3), 32'd0);
    check("abort busy", 32'(busy3), 32'd0);
    check("abort alarm", 32'(alarm3), 32'd0);
    rstN = 1'b1;
    reqValid3 = 4'b1111;
    #1 check("abort next grant ch0", 32'(reqReady3), 32'h1);
    reqValid3 = 4'b0000;
    tick(); tick(); tick(); tick();

    // Alarm: threshold 0xC, ch2 sample 0xF8
    alarmThreshold = 4'hC;
    reqData = {8'h40, 8'hF8, 8'h20, 8'h10};
    reqValid = 4'b0100;
    push1(2'd2, 4'hF);
    tick();
    reqValid = 4'b0000;
    tick();
    check("alarm set", 32'(alarm), 32'(ALARM_CH2));
    tick();
    reqValid = 4'b0100;
    push1(2'd2, 4'hF);
    tick();
    reqValid = 4'b0000;
    alarmClear = 4'b0100;
    tick();
    alarmClear = 4'b0000;
    check("alarm set wins", 32'(alarm), 32'(ALARM_CH2));
    tick();
    alarmClear = 4'b0100;
    tick();
    alarmClear = 4'b0000;
    check("alarm clear alone", 32'(alarm), 32'h0);
    tick(); tick();

    check("dut1 scoreboard drained", 32'(exp1.size()), 32'd0);
    check("dut3 scoreboard drained", 32'(exp3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
